// File: rtl/nibble_hex_tx.sv
// Watches a 4-bit bus and sends each new value as an ASCII hex digit in a UART 8N1 frame.
// One pending slot coalesces changes seen mid-frame; overwriting it pulses ovf.
module nibble_hex_tx #(
    parameter int unsigned BAUD_DIV = 104,
    parameter int unsigned CW       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] data,
    output logic       tx,
    output logic       busy,
    output logic       ovf
);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    localparam logic [CW-1:0] LastCnt = CW'(BAUD_DIV - 1);

    state_e          state_q, state_d;
    logic [3:0]      data_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      sr_q, sr_d;
    logic            pend_q, pend_d;
    logic [3:0]      pend_val_q, pend_val_d;
    logic            ovf_q, ovf_d;
    logic            change;
    logic            tc;
    logic            stop_end;

    function automatic logic [7:0] hex_ascii(input logic [3:0] v);
        return (v < 4'd10) ? 8'h30 + {4'h0, v} : 8'h37 + {4'h0, v};
    endfunction

    assign change   = (data != data_q);
    assign tc       = (cnt_q == LastCnt);
    assign stop_end = (state_q == StStop) && tc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            data_q     <= 4'h0;
            cnt_q      <= '0;
            bit_q      <= 3'd0;
            sr_q       <= 8'h00;
            pend_q     <= 1'b0;
            pend_val_q <= 4'h0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            sr_q       <= sr_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            ovf_q      <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        sr_d    = sr_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (change) begin
                    state_d = StStart;
                    sr_d    = hex_ascii(data);
                end
            end
            StStart: begin
                if (tc) begin
                    state_d = StData;
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                end
            end
            StData: begin
                if (tc) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        sr_d  = sr_q >> 1;
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            StStop: begin
                if (tc) begin
                    cnt_d = '0;
                    // Back-to-back frames: pending value first, else a change on this very edge.
                    if (pend_q) begin
                        state_d = StStart;
                        sr_d    = hex_ascii(pend_val_q);
                    end else if (change) begin
                        state_d = StStart;
                        sr_d    = hex_ascii(data);
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        ovf_d      = 1'b0;
        if (stop_end && pend_q) begin
            pend_d = 1'b0;
        end
        // A change on the final stop edge with nothing pending starts directly instead.
        if (change && (state_q != StIdle) && !(stop_end && !pend_q)) begin
            pend_d     = 1'b1;
            pend_val_d = data;
            ovf_d      = pend_q;
        end
    end

    always_comb begin
        tx   = 1'b1;
        busy = 1'b1;
        unique case (state_q)
            StIdle:  busy = 1'b0;
            StStart: tx   = 1'b0;
            StData:  tx   = sr_q[0];
            StStop:  tx   = 1'b1;
            default: begin
                tx   = 1'b1;
                busy = 1'b0;
            end
        endcase
        ovf = ovf_q;
    end

endmodule

// File: tb/tb_nibble_hex_tx.sv
// Random and directed stimulus for nibble_hex_tx, checked cycle by cycle against a
// frame-timestamp model of the serial line.
module tb_nibble_hex_tx;

    localparam int B = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] data = 4'h0;
    logic       tx;
    logic       busy;
    logic       ovf;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: a frame is its start edge plus the byte carried.
    int         cyc;
    bit         m_active;
    int         m_start;
    logic [7:0] m_byte;
    bit         m_pend;
    logic [3:0] m_pend_val;
    logic [3:0] m_prev;
    bit         m_ovf;

    nibble_hex_tx #(
        .BAUD_DIV(B),
        .CW      (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .data(data),
        .tx  (tx),
        .busy(busy),
        .ovf (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %b expected %b", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [7:0] ascii_of(input logic [3:0] v);
        return (v < 4'd10) ? 8'(48 + int'(v)) : 8'(55 + int'(v));
    endfunction

    function automatic logic exp_tx();
        int idx;
        if (!m_active) return 1'b1;
        idx = (cyc - m_start) / B;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return m_byte[idx-1];
        return 1'b1;
    endfunction

    task automatic model_reset();
        cyc      = 0;
        m_active = 0;
        m_start  = 0;
        m_byte   = 8'h00;
        m_pend   = 0;
        m_pend_val = 4'h0;
        m_prev   = 4'h0;
        m_ovf    = 0;
    endtask

    task automatic start_frame(input logic [7:0] b);
        m_active = 1;
        m_start  = cyc;
        m_byte   = b;
    endtask

    task automatic model_edge();
        bit ev, was_active, old_pend, ending;
        cyc++;
        ev         = (data != m_prev);
        m_prev     = data;
        was_active = m_active;
        old_pend   = m_pend;
        m_ovf      = 0;
        ending     = m_active && (cyc - m_start == 10 * B);
        if (ending) begin
            m_active = 0;
            if (old_pend) begin
                start_frame(ascii_of(m_pend_val));
                m_pend = 0;
            end
        end
        if (ev) begin
            if (was_active && !(ending && !old_pend)) begin
                m_ovf      = old_pend;
                m_pend     = 1;
                m_pend_val = data;
            end else begin
                start_frame(ascii_of(data));
            end
        end
    endtask

    task automatic step(input logic [3:0] d);
        data = d;
        @(posedge clk);
        model_edge();
        #1;
        check("tx", tx, exp_tx());
        check("busy", busy, m_active);
        check("ovf", ovf, m_ovf);
    endtask

    task automatic hold(input logic [3:0] d, input int n);
        for (int i = 0; i < n; i++) step(d);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        rst = 1'b0;

        // Idle with zero data.
        hold(4'h0, 100);
        // Single frame '5', then back to '0'.
        hold(4'h5, 50);
        hold(4'h0, 50);
        // 'A' then 'F' during its frame.
        hold(4'hA, 10);
        hold(4'hF, 90);
        hold(4'h0, 50);
        // Coalescing: 1 at clock 0, 2 at clock 8, 3 at clock 12.
        hold(4'h1, 8);
        hold(4'h2, 4);
        hold(4'h3, 90);
        // Change exactly on the final stop edge with nothing pending.
        hold(4'h6, 40);
        hold(4'h9, 60);

        // Reset mid-frame, asserted between edges.
        hold(4'h8, 15);
        #2 rst = 1'b1;
        #1;
        check("abort_tx", tx, 1'b1);
        check("abort_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        check("abort_ovf", ovf, 1'b0);
        rst = 1'b0;
        model_reset();
        hold(4'h7, 50);

        // Random gaps around and across frame boundaries.
        for (int i = 0; i < 120; i++) begin
            hold(4'($urandom), int'($urandom_range(1, 45)));
        end
        hold(data, 50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
